// File: rtl/wb_bus_initiator.sv
// Wishbone classic single-transfer initiator: one command, one CYC/STB cycle, one response. STB follows the command edge; rsp_valid follows the ACK/ERR edge.
// cmd_ready stays low until the response is taken. WB_INIT_TIMEOUT_EN adds an STB watchdog that aborts after TIMEOUT cycles.
module wb_bus_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
`ifdef WB_INIT_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_q, wd_d;
  logic        rsp_timeout_q, rsp_timeout_d;
`endif

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_bus_initiator: TIMEOUT must be within 2..65535");
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
`ifdef WB_INIT_TIMEOUT_EN
    wd_d          = wd_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          state_d = BUS;
`ifdef WB_INIT_TIMEOUT_EN
          wd_d = '0;
`endif
        end
      end
      BUS: begin
        // ERR outranks ACK when a slave raises both in the same cycle.
        if (wbm_err_i) begin
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
          state_d   = RESP;
`ifdef WB_INIT_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end else if (wbm_ack_i) begin
          rsp_err_d = 1'b0;
          rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
          state_d   = RESP;
`ifdef WB_INIT_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end
`ifdef WB_INIT_TIMEOUT_EN
        else if (wd_q == TO_LAST) begin
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_dat_d     = '0;
          state_d       = RESP;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
`ifdef WB_INIT_TIMEOUT_EN
      wd_q          <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
`ifdef WB_INIT_TIMEOUT_EN
      wd_q          <= wd_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  // Handshake and bus strobes decode straight from the state flop, so reset drops CYC/STB at once.
  assign cmd_ready = (state_q == IDLE);
  assign wbm_cyc_o = (state_q == BUS);
  assign wbm_stb_o = (state_q == BUS);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
`ifdef WB_INIT_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule
